// File: rtl/data_cache.sv
// data_cache: direct-mapped write-through, no-write-allocate data cache with word-serial line refill.
module data_cache #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LINES      = 64,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cpu_rd_en_i,
  input  logic                     cpu_wr_en_i,
  input  logic [2:0]               cpu_funct3_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_data_i,
  output logic [DATA_WIDTH-1:0]    cpu_data_o,
  output logic                     stall_o,
  input  logic                     flush_i,
  output logic                     mem_rd_en_o,
  output logic                     mem_wr_en_o,
  output logic [2:0]               mem_funct3_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_data_o,
  input  logic [DATA_WIDTH-1:0]    mem_data_i
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);
  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = ADDRESS_WIDTH - IW - WW - OW;
  typedef enum logic {IDLE, REFILL} state_t;
  state_t                state;
  logic [WW-1:0]         cnt;
  logic [NUM_LINES-1:0]  valid_q;
  logic                  flush_pend;
  logic [TW-1:0]         tag_q [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_q [NUM_LINES*WORDS_PER_LINE];
  logic [OW-1:0]         off;
  logic [WW-1:0]         wsel;
  logic [IW-1:0]         idx;
  logic [TW-1:0]         tag;
  logic                  hit, refill, st, ld, miss, last;
  logic [DATA_WIDTH-1:0] word, sh, ext, wdata, merged;
  logic [NB-1:0]         be;
  assign {tag, idx, wsel, off} = cpu_addr_i;
  always_comb begin
    hit    = valid_q[idx] && tag_q[idx] == tag;
    refill = state == REFILL;
    st     = !refill && cpu_wr_en_i;
    ld     = !refill && cpu_rd_en_i && !cpu_wr_en_i;
    miss   = ld && !hit;
    last   = cnt == WW'(WORDS_PER_LINE - 1);
    word   = data_q[{idx, wsel}];
    sh     = word >> {off, 3'b000};
    ext    = cpu_funct3_i[1:0] == 2'b00 ? {{(DATA_WIDTH-8){~cpu_funct3_i[2] & sh[7]}}, sh[7:0]} :
             cpu_funct3_i[1:0] == 2'b01 ? {{(DATA_WIDTH-16){~cpu_funct3_i[2] & sh[15]}}, sh[15:0]} : sh;
    be     = cpu_funct3_i[1:0] == 2'b00 ? NB'(1) << off :
             cpu_funct3_i[1:0] == 2'b01 ? NB'(3) << off : '1;
    wdata  = cpu_data_i << {off, 3'b000};
    merged = word;
    for (int i = 0; i < NB; i++)
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end
  // Every output is forced to zero while reset is held, including store pass-through.
  always_comb begin
    cpu_data_o   = rst_ni && ld && hit ? ext : '0;
    stall_o      = rst_ni && (miss || refill);
    mem_rd_en_o  = rst_ni && refill;
    mem_wr_en_o  = rst_ni && st;
    mem_funct3_o = !rst_ni ? 3'b000 : refill ? 3'b010 : st ? cpu_funct3_i : 3'b000;
    mem_addr_o   = !rst_ni ? '0 : refill ? {tag, idx, cnt, {OW{1'b0}}} : st ? cpu_addr_i : '0;
    mem_data_o   = rst_ni && st ? cpu_data_i : '0;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      cnt        <= '0;
      valid_q    <= '0;
      flush_pend <= 1'b0;
    end else if (refill) begin
      cnt <= last ? '0 : cnt + WW'(1);
      if (last) begin
        state        <= IDLE;
        valid_q[idx] <= 1'b1;
      end
      if (flush_i) flush_pend <= 1'b1;
    end else if (miss) begin
      state <= REFILL;
      cnt   <= '0;
      if (flush_i) flush_pend <= 1'b1;
    end else if (flush_i || flush_pend) begin
      valid_q    <= '0;
      flush_pend <= 1'b0;
    end
  end
  // Storage arrays carry no reset; validity alone decides whether their contents matter.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_q[{idx, cnt}] <= mem_data_i;
      if (last) tag_q[idx] <= tag;
    end else if (st && hit) begin
      data_q[{idx, wsel}] <= merged;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: vector table plus scoreboard checks of data_cache against a byte-addressed memory model.
module tb_data_cache;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cpu_rd_en_i, cpu_wr_en_i, flush_i;
  logic [2:0]  cpu_funct3_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic        stall_o, mem_rd_en_o, mem_wr_en_o;
  logic [2:0]  mem_funct3_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
  always #5 clk_i = ~clk_i;
  data_cache dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cpu_rd_en_i(cpu_rd_en_i), .cpu_wr_en_i(cpu_wr_en_i), .cpu_funct3_i(cpu_funct3_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stall_o(stall_o), .flush_i(flush_i),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_funct3_o(mem_funct3_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
  );
  logic [31:0] mem [0:131071];
  logic [31:0] w;
  assign mem_data_i = mem[mem_addr_o[18:2]];
  always @(posedge clk_i) begin
    if (mem_wr_en_o) begin
      w = mem[mem_addr_o[18:2]];
      case (mem_funct3_o[1:0])
        2'b00:   w[{mem_addr_o[1:0], 3'b000} +: 8]  = mem_data_o[7:0];
        2'b01:   w[{mem_addr_o[1:0], 3'b000} +: 16] = mem_data_o[15:0];
        default: w = mem_data_o;
      endcase
      mem[mem_addr_o[18:2]] <= w;
    end
  end
  typedef struct {
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          stalls;
  } vec_t;
  vec_t        vecs[$];
  vec_t        sb[$];
  logic [31:0] rd_addrs[$];
  int          n_tests = 0;
  int          n_fail = 0;
  function automatic vec_t mk(bit wr, logic [2:0] f3, logic [31:0] a, logic [31:0] d,
                              logic [31:0] x, int s);
    mk.wr = wr; mk.f3 = f3; mk.addr = a; mk.wdata = d; mk.exp = x; mk.stalls = s;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    cpu_rd_en_i  = !v.wr;
    cpu_wr_en_i  = v.wr;
    cpu_funct3_i = v.f3;
    cpu_addr_i   = v.addr;
    cpu_data_i   = v.wdata;
    sb.push_back(v);
  endtask
  task automatic finish_vec(input string name, input int pre);
    int   stalls;
    vec_t e;
    stalls = pre;
    rd_addrs.delete();
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      if (!stall_o) break;
      if (mem_rd_en_o) rd_addrs.push_back(mem_addr_o);
      stalls++;
    end
    e = sb.pop_front();
    chk({name, " stall cycles"}, stalls, e.stalls);
    if (e.wr) begin
      chk({name, " mem_wr_en"}, {31'b0, mem_wr_en_o}, 32'd1);
      chk({name, " mem_addr"}, mem_addr_o, e.addr);
      chk({name, " mem_data"}, mem_data_o, e.wdata);
      chk({name, " mem_funct3"}, {29'b0, mem_funct3_o}, {29'b0, e.f3});
    end else begin
      chk({name, " cpu_data"}, cpu_data_o, e.exp);
    end
    @(posedge clk_i);
    #1;
    cpu_rd_en_i = 1'b0;
    cpu_wr_en_i = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 32'h0;
    mem[32'h10000 >> 2] = 32'h11223344;
    mem[32'h10004 >> 2] = 32'h55667788;
    mem[32'h10008 >> 2] = 32'h99AABBCC;
    mem[32'h1000C >> 2] = 32'hDDEEFF00;
    mem[32'h10400 >> 2] = 32'h0BADC0DE;
    mem[32'h10010 >> 2] = 32'h12345678;
    mem[32'h30000 >> 2] = 32'h30303030;
    mem[32'h40000 >> 2] = 32'h40404040;
    vecs.push_back(mk(0, 3'b010, 32'h10000, 0, 32'h11223344, 5));
    vecs.push_back(mk(0, 3'b000, 32'h1000B, 0, 32'hFFFFFF99, 0));
    vecs.push_back(mk(0, 3'b100, 32'h1000B, 0, 32'h00000099, 0));
    vecs.push_back(mk(0, 3'b001, 32'h1000A, 0, 32'hFFFF99AA, 0));
    vecs.push_back(mk(0, 3'b101, 32'h1000A, 0, 32'h000099AA, 0));
    vecs.push_back(mk(0, 3'b001, 32'h10004, 0, 32'h00007788, 0));
    vecs.push_back(mk(1, 3'b000, 32'h10001, 32'h000000A5, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h10000, 0, 32'h1122A544, 0));
    vecs.push_back(mk(1, 3'b001, 32'h1000E, 32'h0000BEEF, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h1000C, 0, 32'hBEEFFF00, 0));
    vecs.push_back(mk(1, 3'b010, 32'h20000, 32'hCAFEF00D, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h10000, 0, 32'h1122A544, 0));
    vecs.push_back(mk(0, 3'b010, 32'h20000, 0, 32'hCAFEF00D, 5));
    vecs.push_back(mk(0, 3'b010, 32'h10000, 0, 32'h1122A544, 5));
    vecs.push_back(mk(0, 3'b010, 32'h10400, 0, 32'h0BADC0DE, 5));
    vecs.push_back(mk(0, 3'b010, 32'h10000, 0, 32'h1122A544, 5));
    vecs.push_back(mk(0, 3'b010, 32'h1000C, 0, 32'hBEEFFF00, 0));
    cpu_rd_en_i = 1'b1; cpu_wr_en_i = 1'b1; cpu_funct3_i = 3'b010;
    cpu_addr_i = 32'h10000; cpu_data_i = 32'hDEADBEEF; flush_i = 1'b0;
    #12;
    chk("reset stall", {31'b0, stall_o}, 32'd0);
    chk("reset cpu_data", cpu_data_o, 32'd0);
    chk("reset mem_wr_en", {31'b0, mem_wr_en_o}, 32'd0);
    chk("reset mem_addr", mem_addr_o, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cpu_rd_en_i = 1'b0;
    cpu_wr_en_i = 1'b0;
    @(negedge clk_i);
    chk("idle mem_addr", mem_addr_o, 32'd0);
    chk("idle mem_data", mem_data_o, 32'd0);
    chk("idle cpu_data", cpu_data_o, 32'd0);
    @(posedge clk_i);
    #1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      finish_vec($sformatf("vec%0d", i), 0);
      if (i == 0) begin
        chk("refill beats", rd_addrs.size(), 32'd4);
        for (int k = 0; k < 4 && k < rd_addrs.size(); k++)
          chk($sformatf("refill addr%0d", k), rd_addrs[k], 32'h10000 + 32'(4 * k));
      end
    end
    drive(mk(0, 3'b010, 32'h30000, 0, 32'h30303030, 5));
    repeat (3) @(negedge clk_i);
    chk("pre-reset stall", {31'b0, stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid-refill reset stall", {31'b0, stall_o}, 32'd0);
    chk("mid-refill reset mem_rd_en", {31'b0, mem_rd_en_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    finish_vec("reload after reset", 0);
    drive(mk(0, 3'b010, 32'h40000, 0, 32'h40404040, 5));
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    finish_vec("refill with flush", 2);
    drive(mk(0, 3'b010, 32'h40000, 0, 32'h40404040, 5));
    finish_vec("reload after pending flush", 0);
    drive(mk(0, 3'b010, 32'h10010, 0, 32'h12345678, 5));
    finish_vec("fill 0x10010", 0);
    flush_i = 1'b1;
    drive(mk(0, 3'b010, 32'h10010, 0, 32'h12345678, 0));
    finish_vec("hit with flush", 0);
    flush_i = 1'b0;
    drive(mk(0, 3'b010, 32'h10010, 0, 32'h12345678, 5));
    finish_vec("reload after idle flush", 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
